// File: rtl/ctrl_resolve_wb_if.sv
// Bus bundle between the control execute pipe, fetch redirect, CTI queue, active list,
// register file and CSR file for the control writeback/resolution stage.
interface ctrl_resolve_wb_if #(
    parameter int AL_LOG     = 7,
    parameter int PC_W       = 32,
    parameter int DATA_W     = 64,
    parameter int PREG_LOG   = 7,
    parameter int CTI_LOG    = 4,
    parameter int CSR_ADDR_W = 12
) ();
    logic                  flush_i;
    logic [AL_LOG-1:0]     alHead_i;
    logic                  wbValid_i;
    logic [AL_LOG-1:0]     wbAlID_i;
    logic [CTI_LOG-1:0]    wbCtiID_i;
    logic [PREG_LOG-1:0]   wbPhyDest_i;
    logic                  wbDestValid_i;
    logic [DATA_W-1:0]     wbDestData_i;
    logic [PC_W-1:0]       wbNextPC_i;
    logic                  wbCtrlDir_i;
    logic                  wbMispredict_i;
    logic                  wbCsrWrEn_i;
    logic [CSR_ADDR_W-1:0] wbCsrWrAddr_i;
    logic [DATA_W-1:0]     wbCsrWrData_i;
    logic                  stall_o;
    logic                  rfWrEn_o;
    logic [PREG_LOG-1:0]   rfWrAddr_o;
    logic [DATA_W-1:0]     rfWrData_o;
    logic                  ctiUpdValid_o;
    logic [CTI_LOG-1:0]    ctiUpdID_o;
    logic                  ctiUpdDir_o;
    logic [PC_W-1:0]       ctiUpdTarget_o;
    logic                  alDoneValid_o;
    logic [AL_LOG-1:0]     alDoneID_o;
    logic                  recoverReq_o;
    logic [PC_W-1:0]       recoverPC_o;
    logic [AL_LOG-1:0]     recoverAlID_o;
    logic                  recoverAck_i;
    logic                  csrValid_o;
    logic [CSR_ADDR_W-1:0] csrAddr_o;
    logic [DATA_W-1:0]     csrData_o;
    logic                  csrReady_i;

    modport master (
        output flush_i, alHead_i, wbValid_i, wbAlID_i, wbCtiID_i, wbPhyDest_i,
               wbDestValid_i, wbDestData_i, wbNextPC_i, wbCtrlDir_i, wbMispredict_i,
               wbCsrWrEn_i, wbCsrWrAddr_i, wbCsrWrData_i, recoverAck_i, csrReady_i,
        input  stall_o, rfWrEn_o, rfWrAddr_o, rfWrData_o, ctiUpdValid_o, ctiUpdID_o,
               ctiUpdDir_o, ctiUpdTarget_o, alDoneValid_o, alDoneID_o, recoverReq_o,
               recoverPC_o, recoverAlID_o, csrValid_o, csrAddr_o, csrData_o
    );

    modport slave (
        input  flush_i, alHead_i, wbValid_i, wbAlID_i, wbCtiID_i, wbPhyDest_i,
               wbDestValid_i, wbDestData_i, wbNextPC_i, wbCtrlDir_i, wbMispredict_i,
               wbCsrWrEn_i, wbCsrWrAddr_i, wbCsrWrData_i, recoverAck_i, csrReady_i,
        output stall_o, rfWrEn_o, rfWrAddr_o, rfWrData_o, ctiUpdValid_o, ctiUpdID_o,
               ctiUpdDir_o, ctiUpdTarget_o, alDoneValid_o, alDoneID_o, recoverReq_o,
               recoverPC_o, recoverAlID_o, csrValid_o, csrAddr_o, csrData_o
    );
endinterface

// File: rtl/ctrl_resolve_wb.sv
// Control pipe writeback/resolution: registers the packet, strobes RF/CTI/active-list updates,
// holds the oldest outstanding mispredict redirect for fetch, and buffers one CSR write.
module ctrl_resolve_wb #(
    parameter int AL_LOG     = 7,
    parameter int PC_W       = 32,
    parameter int DATA_W     = 64,
    parameter int PREG_LOG   = 7,
    parameter int CTI_LOG    = 4,
    parameter int CSR_ADDR_W = 12
) (
    input logic              clk,
    input logic              reset_n,
    ctrl_resolve_wb_if.slave bus
);
    typedef enum logic {IDLE, REQ} recState_t;

    recState_t recState, recStateNext;
    logic      recLoad;

    logic                  s1Valid;
    logic                  s1DestValid;
    logic [PREG_LOG-1:0]   s1PhyDest;
    logic [DATA_W-1:0]     s1DestData;
    logic [CTI_LOG-1:0]    s1CtiID;
    logic                  s1Dir;
    logic [PC_W-1:0]       s1NextPC;
    logic [AL_LOG-1:0]     s1AlID;

    logic [PC_W-1:0]       recPC;
    logic [AL_LOG-1:0]     recAlID;

    logic                  csrFull;
    logic [CSR_ADDR_W-1:0] csrAddr;
    logic [DATA_W-1:0]     csrData;

    logic                  accept;
    logic                  acceptMisp;
    logic                  newIsOlder;
    logic [AL_LOG-1:0]     newAge;
    logic [AL_LOG-1:0]     heldAge;

    assign bus.stall_o = csrFull && !bus.csrReady_i;
    assign accept      = bus.wbValid_i && !bus.stall_o && !bus.flush_i;
    assign acceptMisp  = accept && bus.wbMispredict_i;

    // Ages are distances from the active-list head, so wrap-around falls out of the modular subtract.
    assign newAge     = bus.wbAlID_i - bus.alHead_i;
    assign heldAge    = recAlID - bus.alHead_i;
    assign newIsOlder = newAge < heldAge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1Valid     <= 1'b0;
            s1DestValid <= 1'b0;
            s1PhyDest   <= '0;
            s1DestData  <= '0;
            s1CtiID     <= '0;
            s1Dir       <= 1'b0;
            s1NextPC    <= '0;
            s1AlID      <= '0;
        end else begin
            s1Valid <= accept;
            if (accept) begin
                s1DestValid <= bus.wbDestValid_i;
                s1PhyDest   <= bus.wbPhyDest_i;
                s1DestData  <= bus.wbDestData_i;
                s1CtiID     <= bus.wbCtiID_i;
                s1Dir       <= bus.wbCtrlDir_i;
                s1NextPC    <= bus.wbNextPC_i;
                s1AlID      <= bus.wbAlID_i;
            end
        end
    end

    // An ack retires the held redirect, but an older mispredict arriving that cycle takes its place.
    always_comb begin
        recStateNext = recState;
        recLoad      = 1'b0;
        if (bus.flush_i) begin
            recStateNext = IDLE;
        end else begin
            case (recState)
                IDLE: begin
                    if (acceptMisp) begin
                        recStateNext = REQ;
                        recLoad      = 1'b1;
                    end
                end
                REQ: begin
                    if (acceptMisp && newIsOlder) begin
                        recLoad = 1'b1;
                    end else if (bus.recoverAck_i) begin
                        recStateNext = IDLE;
                    end
                end
                default: recStateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            recState <= IDLE;
            recPC    <= '0;
            recAlID  <= '0;
        end else begin
            recState <= recStateNext;
            if (recLoad) begin
                recPC   <= bus.wbNextPC_i;
                recAlID <= bus.wbAlID_i;
            end
        end
    end

    // CSR writes are already in commit order, so flush leaves a buffered entry alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csrFull <= 1'b0;
            csrAddr <= '0;
            csrData <= '0;
        end else if (accept && bus.wbCsrWrEn_i) begin
            csrFull <= 1'b1;
            csrAddr <= bus.wbCsrWrAddr_i;
            csrData <= bus.wbCsrWrData_i;
        end else if (csrFull && bus.csrReady_i) begin
            csrFull <= 1'b0;
        end
    end

    assign bus.rfWrEn_o       = s1Valid && s1DestValid;
    assign bus.rfWrAddr_o     = s1PhyDest;
    assign bus.rfWrData_o     = s1DestData;
    assign bus.ctiUpdValid_o  = s1Valid;
    assign bus.ctiUpdID_o     = s1CtiID;
    assign bus.ctiUpdDir_o    = s1Dir;
    assign bus.ctiUpdTarget_o = s1NextPC;
    assign bus.alDoneValid_o  = s1Valid;
    assign bus.alDoneID_o     = s1AlID;
    assign bus.recoverReq_o   = (recState == REQ);
    assign bus.recoverPC_o    = recPC;
    assign bus.recoverAlID_o  = recAlID;
    assign bus.csrValid_o     = csrFull;
    assign bus.csrAddr_o      = csrAddr;
    assign bus.csrData_o      = csrData;
endmodule
